// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4-to-1 mux: steps s1:s0 through channels 0..3 with a DWELL-cycle hold and samples f.
// Optional change detector on completed snapshots enabled by defining MUX_SCAN_CHANGE_DET_EN.
module mux_scan_ctrl #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cont,
  input  logic       f,
  output logic       s0,
  output logic       s1,
  output logic       busy,
  output logic [3:0] snap,
  output logic       snap_valid,
  output logic [7:0] frame_cnt
`ifdef MUX_SCAN_CHANGE_DET_EN
  ,
  output logic       changed
`endif
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);

  state_t     state, state_nx;
  logic [1:0] chan;
  logic [7:0] dcnt;
  logic [2:0] shadow;
  logic       last_dwell;
  logic       frame_done;

  assign last_dwell = (state == SCAN) && (dcnt == DWELL_M1);
  assign frame_done = last_dwell && (chan == 2'd3) && !stop;

  // chan is held at 0 outside SCAN, so the selectors come straight from the register
  assign {s1, s0} = chan;
  assign busy     = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !stop) state_nx = SCAN;
      SCAN: begin
        if (stop)                   state_nx = IDLE;
        else if (frame_done && !cont) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chan       <= 2'd0;
      dcnt       <= 8'd0;
      shadow     <= 3'd0;
      snap       <= 4'd0;
      snap_valid <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      snap_valid <= 1'b0;
      if (state != SCAN || stop) begin
        chan <= 2'd0;
        dcnt <= 8'd0;
      end else if (last_dwell) begin
        dcnt <= 8'd0;
        chan <= chan + 2'd1;
        case (chan)
          2'd0: shadow[0] <= f;
          2'd1: shadow[1] <= f;
          2'd2: shadow[2] <= f;
          default: begin
            snap       <= {f, shadow};
            snap_valid <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
          end
        endcase
      end else begin
        dcnt <= dcnt + 8'd1;
      end
    end
  end

`ifdef MUX_SCAN_CHANGE_DET_EN
  logic [3:0] prev_snap;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_snap <= 4'd0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (frame_done) begin
        prev_snap <= {f, shadow};
        changed   <= ({f, shadow} != prev_snap);
      end
    end
  end
`endif

endmodule
